raster_tile_walker: RTL and testbench
=====================================

// Module: raster_tile_walker
// PURPOSE
// - Consumer side of the per-triangle edge-function setup. Takes the three
//   edge values at the bounding-box origin, their per-pixel x/y increments
//   (a/b coefficients) and an integer pixel bounding box.
// - Walks the box in row-major order, one pixel per cycle, updating each edge
//   value by addition only (no multipliers).
// - Emits every covered pixel over a valid/ready stream to the shading stage.
// PARAMETERS
// - COORD_W  16  width of pixel coordinates (unsigned integer pixels)
// - EDGE_W   32  width of signed edge accumulators; a/b sign-extend to this
// - CNT_W    20  width of the covered-fragment counter
// PORTS
// - clk         in   1        clock, all state on rising edge
// - rst_n       in   1        asynchronous active-low reset
// - in_valid    in   1        triangle setup valid
// - in_ready    out  1        walker idle, setup may be accepted
// - e1,e2,e3    in   EDGE_W   signed edge values at (min_x,min_y)
// - a1,a2,a3    in   16       signed edge increment per +1 pixel in x
// - b1,b2,b3    in   16       signed edge increment per +1 pixel in y
// - min_x,max_x in   COORD_W  inclusive bbox x range
// - min_y,max_y in   COORD_W  inclusive bbox y range
// - frag_valid  out  1        covered fragment on frag_x/frag_y
// - frag_ready  in   1        downstream accepts fragment
// - frag_x      out  COORD_W  fragment pixel x
// - frag_y      out  COORD_W  fragment pixel y
// - done        out  1        1-cycle pulse, triangle fully walked
// - frag_count  out  CNT_W    covered fragments of last triangle, valid at done
// BEHAVIOUR
// - Reset values: in_ready=1, frag_valid=0, frag_x=0, frag_y=0, done=0,
//   frag_count=0, FSM=IDLE. Asserting rst_n low mid-walk aborts the triangle.
//   No fragment and no done are produced for it.
// - FSM states: IDLE -> WALK -> DONE -> IDLE.
// - IDLE: in_ready=1. On in_valid&in_ready, register all inputs.
//   Set cur=(min_x,min_y), e_cur=e_row=e*, and clear the counter.
//   - If min_x>max_x or min_y>max_y, go to DONE; no fragments are emitted.
//   - Otherwise go to WALK.
// - WALK: in_ready=0. A pixel is evaluated in any cycle where the output
//   register is empty or is being drained (!frag_valid | frag_ready).
//   - Covered: e1>=0 && e2>=0 && e3>=0, signed compare, boundary inclusive.
//     Next cycle frag_valid=1, frag_x/frag_y=cur, and the counter increments.
//   - Uncovered: frag_valid drops to 0 once any pending fragment is accepted.
//   - Step, same x-row: x<max_x: x+=1, e_cur+=a.
//   - Step, row end: x==max_x and y<max_y: x=min_x, y+=1, e_row+=b,
//     e_cur=e_row+b (both take the new-row value).
//   - Last pixel: x==max_x and y==max_y; go to DONE after it is evaluated.
// - Backpressure: while frag_valid&!frag_ready, frag_x/frag_y/frag_valid and
//   all walk state hold. Throughput is 1 pixel/cycle with frag_ready=1.
// - Latency: the first pixel is evaluated the cycle after acceptance, and its
//   fragment is visible one cycle later.
// - DONE: wait until frag_valid==0 (last fragment accepted), then assert done
//   for 1 cycle with final frag_count, then return to IDLE.
//   in_ready rises the cycle after done.
// - Arithmetic: a/b sign-extend to EDGE_W, two's-complement add with wrap.
//   The setup stage guarantees no overflow inside the bbox. Coordinate
//   increments never wrap because x<=max_x and y<=max_y.
// - frag_count saturates at all-ones.
// - in_valid is ignored outside IDLE. Inputs need only be stable in the
//   accept cycle.
// TESTING
// - T1 right triangle (0,0),(4,0),(0,4): e=(0,16,0), a=(0,-4,4), b=(4,-4,0),
//   bbox 0..4 x 0..4 -> 15 fragments, those with x+y<=4, in row-major order;
//   first (0,0), last (0,4); done with frag_count=15.
// - T2 T1 with frag_ready toggled 1-0-0-1 per cycle -> the same 15 fragments
//   in the same order, none dropped or duplicated; each fragment is held
//   stable while stalled.
// - T3 degenerate bbox min_x=5,max_x=4 -> no frag_valid, done 1 cycle after
//   DONE entry, frag_count=0.
// - T4 single pixel bbox (3,7) with e=(1,0,2) -> one fragment (3,7), boundary
//   e=0 counts as covered; same with e2=-1 -> zero fragments.
// - T5 rst_n low for 1 cycle after the 6th fragment of T1 -> outputs at reset
//   values immediately and in_ready=1. A new T1 then produces all 15
//   fragments again.
// - T6 in_valid held high through T1 with different data -> second setup
//   accepted only after done, and its fragments follow those of the first
//   triangle.

Source files
------------

// File: rtl/raster_tile_walker.sv
// Raster tile walker: steps a triangle's bounding box in row-major order, one
// pixel per cycle, updating edge functions by addition and streaming covered pixels.
module raster_tile_walker #(
    parameter int COORD_W = 16,
    parameter int EDGE_W  = 32,
    parameter int CNT_W   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EDGE_W-1:0]  e1,
    input  logic [EDGE_W-1:0]  e2,
    input  logic [EDGE_W-1:0]  e3,
    input  logic [15:0]        a1,
    input  logic [15:0]        a2,
    input  logic [15:0]        a3,
    input  logic [15:0]        b1,
    input  logic [15:0]        b2,
    input  logic [15:0]        b3,
    input  logic [COORD_W-1:0] min_x,
    input  logic [COORD_W-1:0] max_x,
    input  logic [COORD_W-1:0] min_y,
    input  logic [COORD_W-1:0] max_y,
    output logic               frag_valid,
    input  logic               frag_ready,
    output logic [COORD_W-1:0] frag_x,
    output logic [COORD_W-1:0] frag_y,
    output logic               done,
    output logic [CNT_W-1:0]   frag_count
);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t             state;
    logic [COORD_W-1:0] cur_x, cur_y, lo_x, hi_x, hi_y;
    logic [EDGE_W-1:0]  e_cur [3];
    logic [EDGE_W-1:0]  e_row [3];
    logic [EDGE_W-1:0]  inc_a [3];
    logic [EDGE_W-1:0]  inc_b [3];
    logic [EDGE_W-1:0]  e_in  [3];
    logic [EDGE_W-1:0]  a_in  [3];
    logic [EDGE_W-1:0]  b_in  [3];

    assign e_in[0] = e1;
    assign e_in[1] = e2;
    assign e_in[2] = e3;
    assign a_in[0] = {{(EDGE_W-16){a1[15]}}, a1};
    assign a_in[1] = {{(EDGE_W-16){a2[15]}}, a2};
    assign a_in[2] = {{(EDGE_W-16){a3[15]}}, a3};
    assign b_in[0] = {{(EDGE_W-16){b1[15]}}, b1};
    assign b_in[1] = {{(EDGE_W-16){b2[15]}}, b2};
    assign b_in[2] = {{(EDGE_W-16){b3[15]}}, b3};

    // A pixel is inside when every edge value is non-negative (sign bit clear).
    logic covered, advance, row_end, last_pixel;
    assign covered    = !e_cur[0][EDGE_W-1] && !e_cur[1][EDGE_W-1] && !e_cur[2][EDGE_W-1];
    assign advance    = !frag_valid || frag_ready;
    assign row_end    = (cur_x == hi_x);
    assign last_pixel = row_end && (cur_y == hi_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            done       <= 1'b0;
            frag_count <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            lo_x       <= '0;
            hi_x       <= '0;
            hi_y       <= '0;
            // NOTE: these small register arrays sit in the async-reset block so
            // every flop has a defined value; large RAM-style arrays would not.
            for (int i = 0; i < 3; i++) begin
                e_cur[i] <= '0;
                e_row[i] <= '0;
                inc_a[i] <= '0;
                inc_b[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read sees the
            // pre-edge value and later assignments in the same branch win.
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready   <= 1'b0;
                        cur_x      <= min_x;
                        cur_y      <= min_y;
                        lo_x       <= min_x;
                        hi_x       <= max_x;
                        hi_y       <= max_y;
                        frag_count <= '0;
                        for (int i = 0; i < 3; i++) begin
                            e_cur[i] <= e_in[i];
                            e_row[i] <= e_in[i];
                            inc_a[i] <= a_in[i];
                            inc_b[i] <= b_in[i];
                        end
                        state <= (min_x > max_x || min_y > max_y) ? DONE : WALK;
                    end
                end
                WALK: begin
                    if (advance) begin
                        frag_valid <= covered;
                        if (covered) begin
                            frag_x <= cur_x;
                            frag_y <= cur_y;
                            if (frag_count != '1) frag_count <= frag_count + CNT_W'(1);
                        end
                        if (!row_end) begin
                            cur_x <= cur_x + COORD_W'(1);
                            for (int i = 0; i < 3; i++) e_cur[i] <= e_cur[i] + inc_a[i];
                        end else if (!last_pixel) begin
                            cur_x <= lo_x;
                            cur_y <= cur_y + COORD_W'(1);
                            for (int i = 0; i < 3; i++) begin
                                e_row[i] <= e_row[i] + inc_b[i];
                                e_cur[i] <= e_row[i] + inc_b[i];
                            end
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Drain the final fragment before signalling completion.
                    if (frag_valid) begin
                        if (frag_ready) frag_valid <= 1'b0;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_tile_walker.sv
// Testbench for raster_tile_walker: scoreboard of expected fragments computed
// from the closed-form edge functions, checked as the stream is accepted.
module tb_raster_tile_walker;
    localparam int COORD_W = 16;
    localparam int EDGE_W  = 32;
    localparam int CNT_W   = 20;

    typedef struct packed {
        int e1, e2, e3, a1, a2, a3, b1, b2, b3, x0, x1, y0, y1;
    } tri_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [EDGE_W-1:0]  e1 = '0, e2 = '0, e3 = '0;
    logic [15:0]        a1 = '0, a2 = '0, a3 = '0, b1 = '0, b2 = '0, b3 = '0;
    logic [COORD_W-1:0] min_x = '0, max_x = '0, min_y = '0, max_y = '0;
    logic               frag_valid;
    logic               frag_ready = 1'b1;
    logic [COORD_W-1:0] frag_x, frag_y;
    logic               done;
    logic [CNT_W-1:0]   frag_count;

    raster_tile_walker #(.COORD_W(COORD_W), .EDGE_W(EDGE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .e1(e1), .e2(e2), .e3(e3), .a1(a1), .a2(a2), .a3(a3),
        .b1(b1), .b2(b2), .b3(b3),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y), .done(done), .frag_count(frag_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [31:0] sb [$];
    int cyc = 0, acc_cyc = 0, done_cyc = 0, done_seen = 0, frag_acc = 0, stall_checks = 0;
    int rdy_mode = 0, rdy_idx = 0;
    logic [CNT_W-1:0] last_count = '0;
    logic prev_done = 1'b0, prev_stall = 1'b0;
    logic [COORD_W-1:0] hold_x = '0, hold_y = '0;
    logic [31:0] exp_p;

    always @(posedge clk) cyc++;

    // Downstream ready: always 1, or the repeating 1-0-0-1 pattern.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) frag_ready = 1'b1;
        else begin
            frag_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
            rdy_idx++;
        end
    end

    // Stream monitor: sampled on the falling edge, transfers complete on the next rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                vectors++; stall_checks++;
                if (frag_valid !== 1'b1 || frag_x !== hold_x || frag_y !== hold_y) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)",
                             frag_valid, frag_x, frag_y, hold_x, hold_y);
                end
            end
            prev_stall = frag_valid && !frag_ready;
            hold_x = frag_x;
            hold_y = frag_y;
            if (frag_valid && frag_ready) begin
                vectors++; frag_acc++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frag: got (%0d,%0d) want none", frag_x, frag_y);
                end else begin
                    exp_p = sb.pop_front();
                    if ({frag_x, frag_y} !== exp_p) begin
                        miscompares++;
                        $display("FAIL frag_order: got (%0d,%0d) want (%0d,%0d)",
                                 frag_x, frag_y, exp_p[31:16], exp_p[15:0]);
                    end
                end
            end
            if (done) begin
                vectors++; done_seen++;
                done_cyc = cyc;
                last_count = frag_count;
                if (prev_done) begin
                    miscompares++;
                    $display("FAIL done_pulse: got done high 2 cycles want 1");
                end
            end
            prev_done = done;
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end
    end

    function automatic tri_t mk(input int e1_, e2_, e3_, a1_, a2_, a3_, b1_, b2_, b3_,
                                x0, x1, y0, y1);
        tri_t t;
        t = '{e1_, e2_, e3_, a1_, a2_, a3_, b1_, b2_, b3_, x0, x1, y0, y1};
        return t;
    endfunction

    // Reference: evaluate each edge function in closed form at every bbox pixel.
    task automatic push_expected(input tri_t t, output int n);
        longint v1, v2, v3;
        n = 0;
        for (int y = t.y0; y <= t.y1; y++)
            for (int x = t.x0; x <= t.x1; x++) begin
                v1 = longint'(t.e1) + longint'(t.a1) * (x - t.x0) + longint'(t.b1) * (y - t.y0);
                v2 = longint'(t.e2) + longint'(t.a2) * (x - t.x0) + longint'(t.b2) * (y - t.y0);
                v3 = longint'(t.e3) + longint'(t.a3) * (x - t.x0) + longint'(t.b3) * (y - t.y0);
                if (v1 >= 0 && v2 >= 0 && v3 >= 0) begin
                    sb.push_back({16'(x), 16'(y)});
                    n++;
                end
            end
    endtask

    task automatic drive_inputs(input tri_t t);
        e1 = t.e1; e2 = t.e2; e3 = t.e3;
        a1 = t.a1[15:0]; a2 = t.a2[15:0]; a3 = t.a3[15:0];
        b1 = t.b1[15:0]; b2 = t.b2[15:0]; b3 = t.b3[15:0];
        min_x = t.x0[15:0]; max_x = t.x1[15:0];
        min_y = t.y0[15:0]; max_y = t.y1[15:0];
    endtask

    // Present a setup and return just after the accepting edge.
    task automatic apply_tri(input tri_t t, input bit keep_valid, output int n);
        int k = 0;
        @(posedge clk); #1;
        drive_inputs(t);
        in_valid = 1'b1;
        do begin
            @(negedge clk); k++;
        end while (!in_ready && k < 3000);
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!keep_valid) in_valid = 1'b0;
        push_expected(t, n);
    endtask

    task automatic wait_done(input int exp_cnt, input string name);
        int d0 = done_seen;
        int k = 0;
        while (done_seen == d0 && k < 3000) begin
            @(negedge clk); #1; k++;
        end
        vectors++;
        if (done_seen == d0) begin
            miscompares++;
            $display("FAIL %s_done_timeout: got no done want done", name);
        end else if (last_count !== CNT_W'(exp_cnt)) begin
            miscompares++;
            $display("FAIL %s_count: got %0d want %0d", name, last_count, exp_cnt);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing: got %0d frags outstanding want 0", name, sb.size());
        end
        sb.delete();
        @(negedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_in_ready: got %0b want 1", name, in_ready);
        end
    endtask

    tri_t t1, t2;

    task automatic test_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, frag_valid, done} !== 3'b100 || frag_x !== '0 || frag_y !== '0 ||
            frag_count !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%0b v=%0b d=%0b x=%0d y=%0d cnt=%0d want 1 0 0 0 0 0",
                     in_ready, frag_valid, done, frag_x, frag_y, frag_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_right_triangle();
        int n;
        rdy_mode = 0;
        apply_tri(t1, 1'b0, n);
        @(negedge clk);
        vectors++;
        if (frag_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_latency_early: got frag_valid=%0b want 0", frag_valid);
        end
        @(negedge clk);
        vectors++;
        if (frag_valid !== 1'b1 || frag_x !== 16'd0 || frag_y !== 16'd0) begin
            miscompares++;
            $display("FAIL t1_first_frag: got v=%0b (%0d,%0d) want v=1 (0,0)", frag_valid, frag_x, frag_y);
        end
        wait_done(15, "t1");
    endtask

    task automatic test_backpressure();
        int n;
        int s0 = stall_checks;
        rdy_idx = 0;
        rdy_mode = 1;
        apply_tri(t1, 1'b0, n);
        wait_done(15, "t2");
        rdy_mode = 0;
        vectors++;
        if (stall_checks == s0) begin
            miscompares++;
            $display("FAIL t2_no_stall: got 0 stalled cycles want >0");
        end
    endtask

    task automatic test_degenerate();
        int n;
        apply_tri(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 4, 0, 3), 1'b0, n);
        wait_done(0, "t3");
        vectors++;
        if (done_cyc - acc_cyc != 1) begin
            miscompares++;
            $display("FAIL t3_done_latency: got %0d want 1", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_single_pixel();
        int n;
        apply_tri(mk(1, 0, 2, 5, -3, 7, -2, 4, 1, 3, 3, 7, 7), 1'b0, n);
        wait_done(1, "t4_inside");
        apply_tri(mk(1, -1, 2, 5, -3, 7, -2, 4, 1, 3, 3, 7, 7), 1'b0, n);
        wait_done(0, "t4_outside");
    endtask

    task automatic test_reset_abort();
        int n, d0, k;
        int f0 = frag_acc;
        rdy_mode = 0;
        apply_tri(t1, 1'b0, n);
        k = 0;
        while (frag_acc < f0 + 6 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, frag_valid, done} !== 3'b100 || frag_x !== '0 || frag_y !== '0 ||
            frag_count !== '0) begin
            miscompares++;
            $display("FAIL t5_reset_values: got rdy=%0b v=%0b d=%0b x=%0d y=%0d cnt=%0d want 1 0 0 0 0 0",
                     in_ready, frag_valid, done, frag_x, frag_y, frag_count);
        end
        sb.delete();
        d0 = done_seen;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        vectors++;
        if (done_seen != d0) begin
            miscompares++;
            $display("FAIL t5_abort_done: got %0d done pulses want 0", done_seen - d0);
        end
        apply_tri(t1, 1'b0, n);
        wait_done(15, "t5_rerun");
    endtask

    task automatic test_back_to_back();
        int n, n2, k, d0;
        bit early = 1'b0;
        apply_tri(t1, 1'b1, n);
        drive_inputs(t2);
        d0 = done_seen;
        k = 0;
        while (done_seen == d0 && k < 3000) begin
            @(negedge clk); #1; k++;
            if (in_ready !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL t6_early_ready: got in_ready=1 before done want 0");
        end
        vectors++;
        if (done_seen == d0 || last_count !== CNT_W'(15)) begin
            miscompares++;
            $display("FAIL t6_first_count: got %0d want 15", last_count);
        end
        @(negedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL t6_ready_after_done: got %0b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_expected(t2, n2);
        wait_done(n2, "t6_second");
    endtask

    initial begin
        t1 = mk(0, 16, 0, 0, -4, 4, 4, -4, 0, 0, 4, 0, 4);
        t2 = mk(3, 5, 1, -1, 1, 0, 1, 0, -1, 2, 5, 1, 3);
        test_reset();
        test_right_triangle();
        test_backpressure();
        test_degenerate();
        test_single_pixel();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
